// File: rtl/chain_cmd_master.sv
// rtl/chain_cmd_master.sv - head-end command issuer and telemetry matcher for the board chain
module chain_cmd_master #(
   parameter int TARGET_W    = 8,
   parameter int PAYLOAD_W   = 16,
   parameter int NBOARDS     = 16,
   parameter int TIMEOUT_CYC = 65536
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_val,
   output logic                          req_rdy,
   input  logic [TARGET_W-1:0]           req_target,
   input  logic [PAYLOAD_W-1:0]          req_payload,
   output logic [TARGET_W+PAYLOAD_W-1:0] cmd_out,
   output logic                          cmd_wr,
   input  logic                          tx_rdy,
   input  logic [TARGET_W+PAYLOAD_W-1:0] tlm_in,
   input  logic                          tlm_val,
   output logic                          rsp_val,
   input  logic                          rsp_rdy,
   output logic [1:0]                    rsp_status,
   output logic [PAYLOAD_W-1:0]          rsp_payload,
   output logic                          evt_val,
   output logic [TARGET_W+PAYLOAD_W-1:0] evt_data,
   output logic [15:0]                   cnt_timeout,
   output logic [15:0]                   cnt_unsol
);
   localparam int CMD_W = TARGET_W + PAYLOAD_W;
   localparam int TMR_W = $clog2(TIMEOUT_CYC);
   localparam logic [TARGET_W:0] NB_LIM   = (TARGET_W+1)'(NBOARDS);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RSP} state_t;

   state_t               state_q, state_d;
   logic [TARGET_W-1:0]  tgt_q, tgt_d;
   logic [PAYLOAD_W-1:0] pay_q, pay_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [1:0]           status_q, status_d;
   logic [PAYLOAD_W-1:0] rpay_q, rpay_d;
   logic [15:0]          cnt_to_q, cnt_to_d;
   logic [15:0]          cnt_un_q, cnt_un_d;
   logic                 evt_val_q, evt_val_d;
   logic [CMD_W-1:0]     evt_data_q, evt_data_d;
   logic                 match;

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      pay_d      = pay_q;
      timer_d    = timer_q;
      status_d   = status_q;
      rpay_d     = rpay_q;
      cnt_to_d   = cnt_to_q;
      cnt_un_d   = cnt_un_q;
      evt_val_d  = 1'b0;
      evt_data_d = evt_data_q;
      match      = 1'b0;
      req_rdy    = 1'b0;
      cmd_wr     = 1'b0;
      rsp_val    = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_rdy = 1'b1;
            if (req_val) begin
               tgt_d = req_target;
               pay_d = req_payload;
               if ({1'b0, req_target} >= NB_LIM) begin
                  status_d = 2'd2;
                  rpay_d   = '0;
                  state_d  = S_RSP;
               end else begin
                  state_d = S_SEND;
               end
            end
         end
         S_SEND: begin
            if (tx_rdy) begin
               cmd_wr  = 1'b1;
               timer_d = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            // A match in the expiry cycle still counts as a good response.
            if (tlm_val && (tlm_in[CMD_W-1 -: TARGET_W] == tgt_q)) begin
               match    = 1'b1;
               rpay_d   = tlm_in[PAYLOAD_W-1:0];
               status_d = 2'd0;
               state_d  = S_RSP;
            end else if (timer_q == TMR_LAST) begin
               rpay_d   = '0;
               status_d = 2'd1;
               if (cnt_to_q != 16'hFFFF) cnt_to_d = cnt_to_q + 16'd1;
               state_d  = S_RSP;
            end
         end
         S_RSP: begin
            rsp_val = 1'b1;
            if (rsp_rdy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (tlm_val && !match) begin
         evt_val_d  = 1'b1;
         evt_data_d = tlm_in;
         if (cnt_un_q != 16'hFFFF) cnt_un_d = cnt_un_q + 16'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tgt_q      <= '0;
         pay_q      <= '0;
         timer_q    <= '0;
         status_q   <= '0;
         rpay_q     <= '0;
         cnt_to_q   <= '0;
         cnt_un_q   <= '0;
         evt_val_q  <= 1'b0;
         evt_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         pay_q      <= pay_d;
         timer_q    <= timer_d;
         status_q   <= status_d;
         rpay_q     <= rpay_d;
         cnt_to_q   <= cnt_to_d;
         cnt_un_q   <= cnt_un_d;
         evt_val_q  <= evt_val_d;
         evt_data_q <= evt_data_d;
      end
   end

   assign cmd_out     = {tgt_q, pay_q};
   assign rsp_status  = status_q;
   assign rsp_payload = rpay_q;
   assign evt_val     = evt_val_q;
   assign evt_data    = evt_data_q;
   assign cnt_timeout = cnt_to_q;
   assign cnt_unsol   = cnt_un_q;
endmodule

// File: tb/tb_chain_cmd_master.sv
// tb/tb_chain_cmd_master.sv - vector table plus scoreboard bench for chain_cmd_master
module tb_chain_cmd_master;
   localparam int TW = 8;
   localparam int PW = 16;
   localparam int NB = 16;
   localparam int TO = 64;

   logic          clock = 1'b0;
   logic          reset, req_val, req_rdy, cmd_wr, tx_rdy, tlm_val;
   logic          rsp_val, rsp_rdy, evt_val;
   logic [TW-1:0] req_target;
   logic [PW-1:0] req_payload, rsp_payload;
   logic [TW+PW-1:0] cmd_out, tlm_in, evt_data;
   logic [1:0]    rsp_status;
   logic [15:0]   cnt_timeout, cnt_unsol;

   chain_cmd_master #(.TARGET_W(TW), .PAYLOAD_W(PW), .NBOARDS(NB), .TIMEOUT_CYC(TO)) dut (
      .clock(clock), .reset(reset), .req_val(req_val), .req_rdy(req_rdy),
      .req_target(req_target), .req_payload(req_payload), .cmd_out(cmd_out),
      .cmd_wr(cmd_wr), .tx_rdy(tx_rdy), .tlm_in(tlm_in), .tlm_val(tlm_val),
      .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_status(rsp_status),
      .rsp_payload(rsp_payload), .evt_val(evt_val), .evt_data(evt_data),
      .cnt_timeout(cnt_timeout), .cnt_unsol(cnt_unsol));

   always #5 clock = ~clock;

   typedef struct {
      logic [TW-1:0] tgt;
      logic [PW-1:0] pay;
      int            tx_hold;
      int            dly;
      bit            send;
      bit            pre;
      logic [PW-1:0] tpay;
      logic [1:0]    exp_status;
      logic [PW-1:0] exp_rpay;
   } vec_t;

   vec_t            vecs[9];
   logic [TW+PW-1:0] exp_cmd_q[$];
   logic [PW+1:0]    exp_rsp_q[$];
   logic [TW+PW-1:0] exp_evt_q[$];
   int n_vec = 0, n_err = 0, cmd_count = 0, model_to = 0, model_un = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: event not expected or never arrived", name);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         if (cmd_wr) begin
            cmd_count++;
            if (exp_cmd_q.size() == 0) fail("cmd_unexpected");
            else check("cmd_out", 32'(cmd_out), 32'(exp_cmd_q.pop_front()));
         end
         if (rsp_val && rsp_rdy) begin
            if (exp_rsp_q.size() == 0) fail("rsp_unexpected");
            else check("rsp", 32'({rsp_status, rsp_payload}), 32'(exp_rsp_q.pop_front()));
         end
         if (evt_val) begin
            if (exp_evt_q.size() == 0) fail("evt_unexpected");
            else check("evt_data", 32'(evt_data), 32'(exp_evt_q.pop_front()));
         end
      end
   end

   task automatic apply(input vec_t v);
      int k;
      int base;
      k = 0;
      while (!req_rdy && k < 200) begin
         @(posedge clock); #1; k++;
      end
      check("req_rdy_idle", 32'(req_rdy), 32'd1);
      tx_rdy      = (v.tx_hold == 0);
      req_val     = 1'b1;
      req_target  = v.tgt;
      req_payload = v.pay;
      exp_rsp_q.push_back({v.exp_status, v.exp_rpay});
      if (v.tgt < NB) exp_cmd_q.push_back({v.tgt, v.pay});
      if (v.exp_status == 2'd1) model_to++;
      if (v.pre) begin
         model_un++;
         exp_evt_q.push_back({8'd0, 16'hAAAA});
      end
      if (v.send && v.exp_status == 2'd1) begin
         model_un++;
         exp_evt_q.push_back({v.tgt, v.tpay});
      end
      base = cmd_count;
      @(posedge clock); #1;
      req_val = 1'b0;
      if (v.tgt < NB) begin
         if (v.tx_hold > 0) begin
            repeat (v.tx_hold) @(posedge clock);
            #1;
            check("no_cmd_while_blocked", 32'(cmd_count), 32'(base));
            tx_rdy = 1'b1;
         end
         k = 0;
         do begin
            @(negedge clock); k++;
         end while (!cmd_wr && k < 200);
         if (!cmd_wr) fail("cmd_wr_wait");
         if (v.send) begin
            for (int i = 1; i <= v.dly; i++) begin
               @(posedge clock); #1;
               tlm_val = (i == v.dly) || (i == 1 && v.pre);
               tlm_in  = (i == v.dly) ? {v.tgt, v.tpay} : {8'd0, 16'hAAAA};
            end
            @(posedge clock); #1;
            tlm_val = 1'b0;
         end else if (v.exp_status == 2'd1) begin
            k = 0;
            do begin
               @(negedge clock); k++;
            end while (!rsp_val && k < 200);
            check("timeout_latency", 32'(k), 32'(TO + 1));
         end
      end
      k = 0;
      while ((exp_rsp_q.size() != 0 || exp_evt_q.size() != 0) && k < 300) begin
         @(negedge clock); k++;
      end
      if (k >= 300) fail("completion_wait");
      repeat (2) @(negedge clock);
      if (v.tgt < NB) check("one_cmd_wr", 32'(cmd_count), 32'(base + 1));
      @(posedge clock); #1;
   endtask

   initial begin
      vecs[0] = '{8'd3,   16'hA5A5, 0,  10, 1'b1, 1'b0, 16'h1234, 2'd0, 16'h1234};
      vecs[1] = '{8'd2,   16'h0202, 20, 5,  1'b1, 1'b0, 16'h2222, 2'd0, 16'h2222};
      vecs[2] = '{8'd5,   16'h0505, 0,  65, 1'b1, 1'b0, 16'h5555, 2'd1, 16'h0000};
      vecs[3] = '{8'd1,   16'h0101, 0,  8,  1'b1, 1'b1, 16'hBBBB, 2'd0, 16'hBBBB};
      vecs[4] = '{8'd15,  16'hFFFF, 3,  64, 1'b1, 1'b0, 16'h0F0F, 2'd0, 16'h0F0F};
      vecs[5] = '{8'd16,  16'h1616, 0,  0,  1'b0, 1'b0, 16'h0000, 2'd2, 16'h0000};
      vecs[6] = '{8'd255, 16'hEEEE, 0,  0,  1'b0, 1'b0, 16'h0000, 2'd2, 16'h0000};
      vecs[7] = '{8'd0,   16'h0000, 0,  1,  1'b1, 1'b0, 16'h0001, 2'd0, 16'h0001};
      vecs[8] = '{8'd7,   16'h0707, 0,  0,  1'b0, 1'b0, 16'h0000, 2'd1, 16'h0000};

      reset = 1'b1; req_val = 1'b0; req_target = '0; req_payload = '0;
      tx_rdy = 1'b1; tlm_val = 1'b0; tlm_in = '0; rsp_rdy = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      check("rst_req_rdy", 32'(req_rdy), 32'd1);
      check("rst_outputs", 32'({cmd_wr, rsp_val, evt_val, rsp_status}), 32'd0);
      check("rst_cmd_out", 32'(cmd_out), 32'd0);
      check("rst_counters", {cnt_timeout, cnt_unsol}, 32'd0);

      for (int i = 0; i < 9; i++) apply(vecs[i]);
      check("cnt_timeout", 32'(cnt_timeout), 32'(model_to));
      check("cnt_unsol", 32'(cnt_unsol), 32'(model_un));

      // Bad target with host stalling the response.
      rsp_rdy = 1'b0;
      req_val = 1'b1; req_target = 8'd16; req_payload = 16'h1616;
      exp_rsp_q.push_back({2'd2, 16'h0000});
      @(posedge clock); #1;
      req_val = 1'b0;
      check("bad_rsp_val", 32'(rsp_val), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         check("hold_rsp", 32'({rsp_val, rsp_status, rsp_payload}), 32'({1'b1, 2'd2, 16'h0000}));
         check("hold_req_rdy", 32'({req_rdy, cmd_wr}), 32'd0);
      end
      rsp_rdy = 1'b1;
      @(posedge clock); #1;
      check("released", 32'({rsp_val, req_rdy}), 32'b01);

      // Reset while waiting for telemetry.
      req_val = 1'b1; req_target = 8'd4; req_payload = 16'h0404;
      exp_cmd_q.push_back({8'd4, 16'h0404});
      exp_rsp_q.push_back({2'd0, 16'h4444});
      @(posedge clock); #1;
      req_val = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      check("pre_rst_req_rdy", 32'(req_rdy), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_rsp_q.delete();
      model_to = 0;
      model_un = 0;
      check("wait_rst_req_rdy", 32'(req_rdy), 32'd1);
      check("wait_rst_outputs", 32'({cmd_wr, rsp_val, evt_val, rsp_status}), 32'd0);
      check("wait_rst_counters", {cnt_timeout, cnt_unsol}, 32'd0);
      apply(vecs[0]);
      apply(vecs[3]);
      check("post_rst_cnt_unsol", 32'(cnt_unsol), 32'(model_un));
      check("post_rst_cnt_timeout", 32'(cnt_timeout), 32'(model_to));
      check("queues_drained", 32'(exp_cmd_q.size() + exp_rsp_q.size() + exp_evt_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
